core_muldiv: RTL and testbench
==============================

// Module: core_muldiv
// PURPOSE
//  Iterative RV32M multiply/divide unit; sequential counterpart of the single-cycle ALU in EX stage.
//  Takes the same operand pair plus an M-extension function code under a start/busy/done handshake.
//  Decode issues the request and stalls the pipeline while busy_out is high.
//  Result goes to the same writeback mux as the ALU result.
// PARAMETERS
//  XLEN        32   operand/result width; only 32 is supported.
//  CNT_W       6    iteration counter width; must hold XLEN.
// PORTS
//  clk        in   1     rising-edge clock, the only clock
//  rst_n      in   1     asynchronous, active-low reset
//  start_in   in   1     request strobe; sampled only in IDLE
//  flush_in   in   1     abort the current operation (pipeline flush)
//  func_in    in   3     `MDFunc_*: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//  opnum1_in  in   XLEN  rs1 (multiplicand / dividend)
//  opnum2_in  in   XLEN  rs2 (multiplier / divisor)
//  busy_out   out  1     high from the cycle after accepted start until done_out cycle inclusive
//  done_out   out  1     one-cycle pulse; res_out valid in that cycle
//  res_out    out  XLEN  result; holds last value until next done
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, busy_out=0, done_out=0, res_out=0, counter=0, internal regs=0.
//  States: IDLE -> CALC -> FIX -> DONE -> IDLE. Fast path: IDLE -> DONE.
//  IDLE: on edge with start_in=1, latch func_in, operands, abs values and result sign.
//   - Go to CALC with counter=0.
//   - Special cases go directly to DONE with precomputed result:
//     DIV/DIVU by 0 -> 0xFFFFFFFF; REM/REMU by 0 -> opnum1.
//     DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
//  CALC: one step per cycle, counter increments, exactly XLEN (32) cycles.
//   - MUL*: shift-add on unsigned magnitudes into a 64-bit product register.
//   - DIV*/REM*: restoring division; quotient/remainder registers, XLEN+1-bit trial subtract.
//   - counter==XLEN-1 -> FIX.
//  FIX: apply sign and select the result.
//   - Negate product if operand signs differ (MULH: both signed; MULHSU: rs1 only).
//   - Quotient sign = s1^s2; remainder sign = s1.
//   - Select low 32 (MUL), high 32 (MULH*), quotient or remainder. Register into res_out. -> DONE.
//  DONE: done_out=1 for exactly one cycle; busy_out=1; -> IDLE.
//  Latency: start edge E0 -> done_out high in the cycle after E33 (34 cycles).
//   Fast path: done_out high in the cycle after E0.
//  start_in while not IDLE is ignored (no queueing). start_in and done_out in the same cycle: ignored.
//  flush_in=1 at any edge: -> IDLE, no done_out, res_out unchanged. Flush has priority over start_in.
//  Mid-operation reset: immediate IDLE, all outputs 0.
//  Operand inputs are don't-care after the start edge; the unit uses only its latched copies.
//  Arithmetic is mod 2^XLEN; no exceptions raised (RV32M semantics).
// STRUCTURE
//  defines.v gains: `MDFuncBus 2:0, `MDFunc_MUL..`MDFunc_REMU (funct3 encoding 0..7),
//   `MDEnable, and state encodings `MDState_IDLE/CALC/FIX/DONE.
//  Reuse `MemByteBus, `ZeroWord from defines.v.
//  One sub-module is natural: core_muldiv_fix (combinational sign-fix/result select),
//   instantiated once for the FIX stage. Datapath and FSM stay in core_muldiv.
// TESTING
//  MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> res 0xFFFFFFEB, done 34 cycles after start.
//  MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE;
//   MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  DIV x/0 -> 0xFFFFFFFF and REM 5/0 -> 5, done 1 cycle after start.
//   DIV 0x80000000/-1 -> 0x80000000; REM same -> 0.
//  Start DIVU, flush_in at cycle 10 -> no done_out, busy_out low next cycle;
//   new start accepted the following cycle completes correctly.
//  Extra start_in pulses while busy are ignored; rst_n low mid-CALC -> all outputs 0 immediately;
//   randomized 1000-op compare vs reference model.

Source files
------------

// File: rtl/core_muldiv_pkg.sv
// core_muldiv_pkg: shared function codes, FSM states and operand-sign helpers for core_muldiv
package core_muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } md_func_e;

    typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIX, MD_DONE} md_state_e;

    function automatic logic rs1_signed(input md_func_e f);
        return f inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic rs2_signed(input md_func_e f);
        return f inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/core_muldiv_fix.sv
// core_muldiv_fix: applies operand signs to the unsigned magnitude result and selects the output word
module core_muldiv_fix
    import core_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  md_func_e          func,
    input  logic              s1,
    input  logic              s2,
    input  logic [2*XLEN-1:0] acc,
    output logic [XLEN-1:0]   res
);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    // product/quotient take sign s1^s2, remainder takes the dividend sign
    always_comb begin
        prod = (s1 ^ s2) ? -acc : acc;
        quo  = (s1 ^ s2) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = s1 ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        res  = (func == MD_MUL) ? prod[XLEN-1:0] :
               !func[2]         ? prod[2*XLEN-1:XLEN] :
               func[1]          ? rem : quo;
    end
endmodule

// File: rtl/core_muldiv.sv
// core_muldiv: iterative RV32M multiply/divide unit with start/busy/done handshake
module core_muldiv
    import core_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_in,
    input  logic            flush_in,
    input  logic [2:0]      func_in,
    input  logic [XLEN-1:0] opnum1_in,
    input  logic [XLEN-1:0] opnum2_in,
    output logic            busy_out,
    output logic            done_out,
    output logic [XLEN-1:0] res_out
);
    md_state_e         state, state_nx;
    md_func_e          func_d, func_q;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc, acc_init, mul_nx, div_nx;
    logic [XLEN-1:0]   mag, mag_d, m1, m2, special_res, fix_res, diff;
    logic [XLEN:0]     mul_sum;
    logic              s1, s2, s1_q, s2_q, div0, ovf, special, ge;

    assign func_d  = md_func_e'(func_in);
    assign s1      = rs1_signed(func_d) & opnum1_in[XLEN-1];
    assign s2      = rs2_signed(func_d) & opnum2_in[XLEN-1];
    assign m1      = s1 ? -opnum1_in : opnum1_in;
    assign m2      = s2 ? -opnum2_in : opnum2_in;
    assign div0    = func_in[2] & (opnum2_in == '0);
    assign ovf     = func_in[2] & !func_in[0] & (opnum1_in == {1'b1, {(XLEN-1){1'b0}}}) & (&opnum2_in);
    assign special = div0 | ovf;
    assign special_res = div0 ? (func_in[1] ? opnum1_in : '1) :
                                (func_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
    // multiply keeps the multiplier in the low half, divide keeps the dividend there
    assign acc_init = {{XLEN{1'b0}}, func_in[2] ? m1 : m2};
    assign mag_d    = func_in[2] ? m2 : m1;
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, acc[0] ? mag : {XLEN{1'b0}}};
    assign mul_nx   = {mul_sum, acc[XLEN-1:1]};
    assign ge       = acc[2*XLEN-1:XLEN-1] >= {1'b0, mag};
    assign diff     = acc[2*XLEN-2:XLEN-1] - mag;
    assign div_nx   = ge ? {diff, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};

    core_muldiv_fix #(.XLEN(XLEN)) u_fix (
        .func(func_q),
        .s1  (s1_q),
        .s2  (s2_q),
        .acc (acc),
        .res (fix_res)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MD_IDLE;
        else        state <= state_nx;
    end

    // next state; flush wins over everything including a new start
    always_comb begin
        state_nx = MD_IDLE;
        if (!flush_in) begin
            case (state)
                MD_IDLE: state_nx = start_in ? (special ? MD_DONE : MD_CALC) : MD_IDLE;
                MD_CALC: state_nx = (cnt == CNT_W'(XLEN-1)) ? MD_FIX : MD_CALC;
                MD_FIX:  state_nx = MD_DONE;
                default: state_nx = MD_IDLE;
            endcase
        end
    end

    // handshake outputs decoded from state
    always_comb begin
        busy_out = state != MD_IDLE;
        done_out = state == MD_DONE;
    end

    // operand latch at accept, one shift-add or restoring-divide step per CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func_q <= MD_MUL;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            mag    <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == MD_IDLE && start_in) begin
            func_q <= func_d;
            s1_q   <= s1;
            s2_q   <= s2;
            mag    <= mag_d;
            acc    <= acc_init;
            cnt    <= '0;
        end else if (state == MD_CALC) begin
            acc    <= func_q[2] ? div_nx : mul_nx;
            cnt    <= cnt + 1'b1;
        end
    end

    // result register loads only on the way into DONE, so a flush leaves it untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  res_out <= '0;
        else if (state_nx == MD_DONE) res_out <= (state == MD_FIX) ? fix_res : special_res;
    end
endmodule

// File: tb/tb_core_muldiv.sv
// tb_core_muldiv: directed and randomized checks of core_muldiv against a latency/arithmetic model
module tb_core_muldiv;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_in = 1'b0;
    logic        flush_in = 1'b0;
    logic [2:0]  func_in = 3'd0;
    logic [31:0] opnum1_in = 32'd0;
    logic [31:0] opnum2_in = 32'd0;
    logic        busy_out, done_out;
    logic [31:0] res_out;

    int n_chk = 0;
    int n_pass = 0;

    int          m_rem = 0;
    logic [31:0] m_res = 32'd0;
    logic [31:0] m_pend = 32'd0;

    core_muldiv dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_in (start_in),
        .flush_in (flush_in),
        .func_in  (func_in),
        .opnum1_in(opnum1_in),
        .opnum2_in(opnum2_in),
        .busy_out (busy_out),
        .done_out (done_out),
        .res_out  (res_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF :
                         (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 :
                         32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a :
                         (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 :
                         32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // model: m_rem counts edges until the unit is idle again; 1 means the done cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_res  <= 32'd0;
            m_pend <= 32'd0;
        end else if (flush_in) begin
            m_rem <= 0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 2) m_res <= m_pend;
        end else if (start_in) begin
            if (is_special(func_in, opnum1_in, opnum2_in)) begin
                m_rem <= 1;
                m_res <= ref_md(func_in, opnum1_in, opnum2_in);
            end else begin
                m_rem  <= 34;
                m_pend <= ref_md(func_in, opnum1_in, opnum2_in);
            end
        end
    end

    // every-cycle compare of the DUT outputs against the model
    always @(negedge clk) begin
        check("cyc_busy", {31'd0, busy_out}, {31'd0, m_rem != 0});
        check("cyc_done", {31'd0, done_out}, {31'd0, m_rem == 1});
        check("cyc_res", res_out, m_res);
    end

    task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e, input int lat);
        int n;
        @(negedge clk);
        func_in = f; opnum1_in = a; opnum2_in = b; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0; func_in = 3'($urandom); opnum1_in = $urandom; opnum2_in = $urandom;
        n = 1;
        while (!done_out && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_lat"}, 32'(n), 32'(lat));
        check({nm, "_res"}, res_out, e);
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        int          n;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy_out}, 32'd0);
        check("rst_done", {31'd0, done_out}, 32'd0);
        check("rst_res", res_out, 32'd0);
        rst_n = 1'b1;

        run_op("mul", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("divu", 3'd5, 32'd100, 32'd7, 32'd14, 34);
        run_op("remu", 3'd7, 32'd100, 32'd7, 32'd2, 34);
        run_op("div0", 3'd4, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem0", 3'd6, 32'd5, 32'd0, 32'd5, 1);
        run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // flush mid-division: no done, busy drops, result register keeps the previous value
        @(negedge clk);
        func_in = 3'd5; opnum1_in = 32'd100; opnum2_in = 32'd7; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        repeat (9) @(negedge clk);
        flush_in = 1'b1;
        @(negedge clk);
        flush_in = 1'b0;
        check("flush_busy", {31'd0, busy_out}, 32'd0);
        check("flush_done", {31'd0, done_out}, 32'd0);
        check("flush_res", res_out, 32'd0);
        run_op("postflush", 3'd5, 32'd1000, 32'd3, 32'd333, 34);

        // start pulses while busy are ignored
        @(negedge clk);
        func_in = 3'd0; opnum1_in = 32'd6; opnum2_in = 32'd9; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        repeat (4) @(negedge clk);
        func_in = 3'd5; opnum1_in = 32'd50; opnum2_in = 32'd0; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        n = 6;
        while (!done_out && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ignore_lat", 32'(n), 32'd34);
        check("ignore_res", res_out, 32'd54);

        // asynchronous reset in the middle of CALC clears outputs at once
        @(negedge clk);
        func_in = 3'd3; opnum1_in = 32'hDEAD_BEEF; opnum2_in = 32'h1234_5678; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy_out}, 32'd0);
        check("arst_done", {31'd0, done_out}, 32'd0);
        check("arst_res", res_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("postrst", 3'd7, 32'hFFFF_FFFF, 32'd10, 32'd5, 34);

        for (int i = 0; i < 1000; i++) begin
            f = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: a = 32'd0;
                1: a = 32'h8000_0000;
                2: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op("rnd", f, a, b, ref_md(f, a, b), is_special(f, a, b) ? 1 : 34);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
